// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one column per cycle through a single shared
// GF(2^8) datapath, with a bypass mode for the final decrypt round.
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic         bypass,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  logic [1:0]   col_r;
  logic [127:0] state_in_r;
  logic         bypass_r;
  logic [127:0] data_out_r;
  logic         busy_r;
  logic         done_r;

  logic [31:0]  col_in_s;
  logic [31:0]  col_res_s;

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) begin
      r = r ^ 8'h1b;
    end else begin
      r = r ^ 8'h00;
    end
    return r;
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Inverse mix of one column; s0 sits in the most significant byte.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] o0, o1, o2, o3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    o0 = gmule(s0) ^ gmulb(s1) ^ gmuld(s2) ^ gmul9(s3);
    o1 = gmul9(s0) ^ gmule(s1) ^ gmulb(s2) ^ gmuld(s3);
    o2 = gmuld(s0) ^ gmul9(s1) ^ gmule(s2) ^ gmulb(s3);
    o3 = gmulb(s0) ^ gmuld(s1) ^ gmul9(s2) ^ gmule(s3);
    return {o0, o1, o2, o3};
  endfunction

  // Select the captured column addressed by the column counter.
  always_comb begin
    col_in_s = 32'h0000_0000;
    case (col_r)
      2'd0:    col_in_s = state_in_r[127:96];
      2'd1:    col_in_s = state_in_r[95:64];
      2'd2:    col_in_s = state_in_r[63:32];
      2'd3:    col_in_s = state_in_r[31:0];
      default: col_in_s = 32'h0000_0000;
    endcase
  end

  // Shared column datapath, or straight copy in bypass mode.
  always_comb begin
    col_res_s = 32'h0000_0000;
    if (bypass_r) begin
      col_res_s = col_in_s;
    end else begin
      col_res_s = inv_col(col_in_s);
    end
  end

  // Control FSM with capture, column write-back and registered status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      col_r      <= 2'd0;
      state_in_r <= 128'h0;
      bypass_r   <= 1'b0;
      data_out_r <= 128'h0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_in_r <= data_in;
            bypass_r   <= bypass;
            col_r      <= 2'd0;
            state_r    <= CALC;
            busy_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CALC: begin
          case (col_r)
            2'd0:    data_out_r[127:96] <= col_res_s;
            2'd1:    data_out_r[95:64]  <= col_res_s;
            2'd2:    data_out_r[63:32]  <= col_res_s;
            2'd3:    data_out_r[31:0]   <= col_res_s;
            default: data_out_r         <= data_out_r;
          endcase
          col_r  <= col_r + 2'd1;
          busy_r <= 1'b1;
          if (col_r == 2'd3) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= CALC;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          // Illegal encoding recovers to a quiet IDLE.
          state_r <= IDLE;
          col_r   <= 2'd0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign data_out = data_out_r;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: directed vectors with hand-derived
// results, protocol model for busy/done timing and column-by-column write-back.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [127:0] data_in;
  logic         bypass;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_next;
  logic [127:0] prev;
  logic [127:0] e_out;
  int           ph;

  localparam logic [127:0] VA_IN = {4{32'h8e4da1bc}};
  localparam logic [127:0] VA_EX = {4{32'hdb135345}};
  localparam logic [127:0] VB_IN = {32'h9fdc589d, 32'hd5d5d7d6, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] VB_EX = {32'hf20a225c, 32'hd4d4d4d5, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] VC_IN = {32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h01010101};
  localparam logic [127:0] VC_EX = {32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h01010101};
  localparam logic [127:0] VP    = 128'h00112233445566778899aabbccddeeff;

  logic [127:0] tbl_in [4];
  logic [127:0] tbl_ex [4];

  inv_mix_columns_seq dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .data_in  (data_in),
    .bypass   (bypass),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  // First n columns from the new result, remaining columns from the old one.
  function automatic logic [127:0] merge(input logic [127:0] nw, input logic [127:0] old, input int n);
    logic [127:0] r;
    r = old;
    for (int c = 0; c < 4; c++) begin
      if (c < n) r[127-32*c -: 32] = nw[127-32*c -: 32];
    end
    return r;
  endfunction

  // Protocol model: phase 0 idle, 1..4 computing, 5 done; pushes on acceptance.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ph <= 0;
      exp_q.delete();
    end else begin
      case (ph)
        0: if (start) begin
             ph <= 1;
             exp_q.push_back(exp_next);
           end
        5: ph <= 0;
        default: ph <= ph + 1;
      endcase
    end
  end

  // Monitor: compare status and output register every cycle, pop on done.
  always @(negedge clk) begin
    if (!n_rst) prev = 128'h0;
    chk("busy", 128'(busy), 128'(ph != 0));
    chk("done", 128'(done), 128'(ph == 5));
    if (ph >= 1 && ph <= 5 && exp_q.size() > 0) e_out = merge(exp_q[0], prev, ph - 1);
    else e_out = prev;
    chk("data_out", data_out, e_out);
    if (ph == 5 && exp_q.size() > 0) prev = exp_q.pop_front();
  end

  task automatic step(input logic s, input logic [127:0] d, input logic b, input logic [127:0] e);
    start    = s;
    data_in  = d;
    bypass   = b;
    exp_next = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 128'h0, 1'b0, 128'h0);
  endtask

  initial begin
    tbl_in[0] = VA_IN; tbl_ex[0] = VA_EX;
    tbl_in[1] = VB_IN; tbl_ex[1] = VB_EX;
    tbl_in[2] = VC_IN; tbl_ex[2] = VC_EX;
    tbl_in[3] = 128'h0; tbl_ex[3] = 128'h0;

    n_rst = 1'b0; start = 1'b0; data_in = 128'h0; bypass = 1'b0; exp_next = 128'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_data", data_out, 128'h0);
    n_rst = 1'b1;

    // Single operations: uniform column, mixed columns, bypass.
    step(1'b1, VA_IN, 1'b0, VA_EX); idle(6);
    step(1'b1, VB_IN, 1'b0, VB_EX); idle(6);
    step(1'b1, VP, 1'b1, VP);       idle(6);

    // Start pulsed in the second computing cycle with other data is ignored.
    step(1'b1, VC_IN, 1'b0, VC_EX);
    step(1'b0, VB_IN, 1'b1, 128'h0);
    step(1'b1, VB_IN, 1'b1, VB_EX);
    idle(8);

    // Reset during the third computing cycle aborts at once.
    step(1'b1, VA_IN, 1'b0, VA_EX);
    step(1'b0, 128'h0, 1'b0, 128'h0);
    step(1'b0, 128'h0, 1'b0, 128'h0);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_done", 128'(done), 128'h0);
    chk("abort_data", data_out, 128'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(8);

    // Continuous start with data changing every cycle.
    for (int i = 0; i < 12; i++) step(1'b1, tbl_in[i % 4], 1'b0, tbl_ex[i % 4]);
    idle(2);

    for (int i = 0; i < 30 && (exp_q.size() != 0 || ph != 0); i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || ph != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, phase %0d, want 0 and 0", exp_q.size(), ph);
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
